// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and default width.
package serial_adder_defs;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell reused by the serial adder for every bit position.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   // Sum and carry of one bit pair plus incoming carry
   always_comb begin
      s    = a ^ b ^ cin;
      cout = (a & b) | (cin & (a ^ b));
   end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder cell walks the operands LSB first, one bit
// per clock, and publishes the parallel sum and final carry with a done pulse.
module serial_adder
   import serial_adder_defs::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t           state;
   state_t           next_state;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] psum;
   logic             carry;
   logic [CW-1:0]    count;
   logic             accept;
   logic             last_bit;
   logic             fa_s;
   logic             fa_cout;

   full_adder u_full_adder (
      .a    (sa[0]),
      .b    (sb[0]),
      .cin  (carry),
      .s    (fa_s),
      .cout (fa_cout)
   );

   // Next-state and control: start is only honoured in IDLE or DONE
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      last_bit   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               next_state = RUN;
            end
         end
         RUN: begin
            if (count == LAST_BIT) begin
               last_bit   = 1'b1;
               next_state = DONE;
            end
         end
         DONE: begin
            if (start) begin
               accept     = 1'b1;
               next_state = RUN;
            end else begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // State register and datapath: load on accept, shift one bit per RUN cycle,
   // and capture the finished result on the final bit
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sa    <= '0;
         sb    <= '0;
         psum  <= '0;
         carry <= 1'b0;
         count <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         state <= next_state;
         if (accept) begin
            sa    <= a;
            sb    <= b;
            carry <= cin;
            count <= '0;
         end else if (state == RUN) begin
            sa    <= sa >> 1;
            sb    <= sb >> 1;
            psum  <= {fa_s, psum[WIDTH-1:1]};
            carry <= fa_cout;
            count <= count + 1'b1;
            if (last_bit) begin
               sum  <= {fa_s, psum[WIDTH-1:1]};
               cout <= fa_cout;
            end
         end
      end
   end

   // Status flags decode straight from the state
   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8.
module tb_serial_adder;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic       busy;
   logic       done;
   logic [7:0] sum;
   logic       cout;

   int errors;
   int checks;

   serial_adder #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   // Free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Presents operands with start for one accepting edge, then scrambles them
   task automatic applyStimulus(input logic [7:0] va, input logic [7:0] vb, input logic vc);
      start = 1'b1;
      a     = va;
      b     = vb;
      cin   = vc;
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = ~va;
      b     = 8'h5A;
      cin   = ~vc;
   endtask

   task automatic test_reset;
      rst   = 1'b1;
      start = 1'b0;
      a     = 8'h00;
      b     = 8'h00;
      cin   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if ({sum, cout, busy, done} !== 11'b0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got sum=%h cout=%b busy=%b done=%b expected all 0", sum, cout, busy, done);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_idle_hold: got busy=%b done=%b expected 0 0", busy, done);
      end
   endtask

   // Runs one addition from idle and checks busy/done timing and the result
   task automatic test_add(input string name, input logic [7:0] va, input logic [7:0] vb,
                           input logic vc, input logic [7:0] exp_sum, input logic exp_cout,
                           input logic [7:0] prev_sum);
      applyStimulus(va, vb, vc);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL %s_busy_t0: got busy=%b done=%b expected 1 0", name, busy, done);
      end
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk);
         #1;
         if (i < 8) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || sum !== prev_sum) begin
               errors++;
               $display("[TB] FAIL %s_run_c%0d: got busy=%b done=%b sum=%h expected 1 0 %h", name, i, busy, done, sum, prev_sum);
            end
         end else begin
            checks++;
            if (done !== 1'b1 || busy !== 1'b0) begin
               errors++;
               $display("[TB] FAIL %s_done: got done=%b busy=%b expected 1 0", name, done, busy);
            end
            checks++;
            if (sum !== exp_sum || cout !== exp_cout) begin
               errors++;
               $display("[TB] FAIL %s_result: got sum=%h cout=%b expected %h %b", name, sum, cout, exp_sum, exp_cout);
            end
         end
      end
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || sum !== exp_sum) begin
         errors++;
         $display("[TB] FAIL %s_after: got done=%b busy=%b sum=%h expected 0 0 %h", name, done, busy, sum, exp_sum);
      end
   endtask

   task automatic test_start_ignored;
      int done_count;
      applyStimulus(8'h3C, 8'h05, 1'b0);
      done_count = 0;
      for (int i = 1; i <= 12; i++) begin
         if (i == 3) begin
            start = 1'b1;
            a     = 8'h11;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
         if (done === 1'b1) begin
            done_count++;
            checks++;
            if (i != 8 || sum !== 8'h41 || cout !== 1'b0) begin
               errors++;
               $display("[TB] FAIL ignored_result: got cycle=%0d sum=%h cout=%b expected 8 41 0", i, sum, cout);
            end
         end
      end
      checks++;
      if (done_count != 1) begin
         errors++;
         $display("[TB] FAIL ignored_done_count: got %0d expected 1", done_count);
      end
   endtask

   task automatic test_reset_abort;
      int done_count;
      applyStimulus(8'h3C, 8'h05, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if ({sum, cout, busy, done} !== 11'b0) begin
         errors++;
         $display("[TB] FAIL abort_outputs: got sum=%h cout=%b busy=%b done=%b expected all 0", sum, cout, busy, done);
      end
      done_count = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1 || busy === 1'b1) done_count++;
      end
      checks++;
      if (done_count != 0) begin
         errors++;
         $display("[TB] FAIL abort_quiet: got %0d active cycles expected 0", done_count);
      end
      test_add("after_abort", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 8'h00);
   endtask

   task automatic test_back_to_back;
      int done_at;
      applyStimulus(8'h3C, 8'h05, 1'b0);
      repeat (8) @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b1 || sum !== 8'h41) begin
         errors++;
         $display("[TB] FAIL b2b_first: got done=%b sum=%h expected 1 41", done, sum);
      end
      applyStimulus(8'h80, 8'h80, 1'b0);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL b2b_no_idle: got busy=%b done=%b expected 1 0", busy, done);
      end
      done_at = 0;
      for (int i = 1; i <= 10 && done_at == 0; i++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) done_at = i;
      end
      checks++;
      if (done_at != 8 || sum !== 8'h00 || cout !== 1'b1) begin
         errors++;
         $display("[TB] FAIL b2b_second: got cycle=%0d sum=%h cout=%b expected 8 00 1", done_at, sum, cout);
      end
   endtask

   // Scenario sequence and summary
   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_add("basic", 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 8'h00);
      test_add("ovf", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8'h41);
      test_add("cin", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 8'h00);
      test_add("mixed", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 8'h00);
      test_add("plain", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 8'h00);
      test_start_ignored();
      test_reset_abort();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
